// File: rtl/time_tracking_window_queue.sv
// -----------------------------------------------------------------------------
// time_tracking_window_queue
//
// A FIFO that timestamps each entry when it is pushed. When an entry is popped,
// the queue reports how many enabled cycles that entry waited. An optional
// age-based expiry drops the head entry once it has waited MAX_AGE enabled
// cycles. This block is the storage element behind sliding-window stream
// buffers in generated RTLola monitors.
//
// Parameters
//   DATA_W   payload width (signed, passed through bit-exact)
//   DEPTH    number of entries, any value >= 1 (power of two not required)
//   TS_W     width of the timestamp and of the waited counter
//   MAX_AGE  expiry threshold in enabled cycles; 0 disables expiry
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset; overrides en
//   en          clock enable; when low, every register holds its value
//   push        enqueue request, carrying payload on data
//   pop         dequeue request
//   data        payload to enqueue
//   push_valid  registered: the push sampled at the last enabled edge was accepted
//   pop_valid   registered: the pop sampled at the last enabled edge returned an entry
//   out         registered popped payload, 0 when pop_valid is 0
//   waited      registered age of the popped entry, 0 when pop_valid is 0
//   expired     registered: the head entry was dropped by expiry at the last edge
//   count       registered occupancy after the last edge
//
// Request/response semantics: push and pop are single-cycle requests. They
// are sampled at an enabled rising edge and are never retried or held off by
// the queue. The matching response flags (push_valid, pop_valid, expired) and
// the payload fields (out, waited) appear after that same edge. They last for
// exactly one enabled cycle and then fall back to 0 unless a new request is
// sampled. While en is low, requests are ignored and responses hold.
// -----------------------------------------------------------------------------
module time_tracking_window_queue #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 5,
    parameter int TS_W    = 32,
    parameter int MAX_AGE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          push,
    input  logic                          pop,
    input  logic signed [DATA_W-1:0]      data,
    output logic                          push_valid,
    output logic                          pop_valid,
    output logic signed [DATA_W-1:0]      out,
    output logic [TS_W-1:0]               waited,
    output logic                          expired,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [TS_W-1:0]  MAX_AGE_TS = TS_W'(MAX_AGE);
    localparam logic             EXPIRY_ON  = (MAX_AGE != 0);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // Payload and timestamp storage. This storage is never reset; head, tail
    // and count alone define which slots hold live entries.
    logic signed [DATA_W-1:0] data_mem [DEPTH];
    logic [TS_W-1:0]          ts_mem   [DEPTH];

    logic [TS_W-1:0]  t;      // free-running enabled-cycle timestamp
    logic [PTR_W-1:0] head;   // oldest live entry
    logic [PTR_W-1:0] tail;   // next slot to write

    // -------------------------------------------------------------------------
    // Per-edge decisions
    // -------------------------------------------------------------------------
    logic                     empty;
    logic                     full;
    logic signed [DATA_W-1:0] head_data;
    logic [TS_W-1:0]          head_age;
    logic                     pop_acc;
    logic                     exp_acc;
    logic                     push_acc;
    logic                     head_adv;
    logic [PTR_W-1:0]         head_next;
    logic [PTR_W-1:0]         tail_next;
    logic [CNT_W-1:0]         count_next;

    // Advance a pointer around a ring of DEPTH slots. DEPTH does not have to
    // be a power of two, so an explicit wrap is needed.
    function automatic logic [PTR_W-1:0] ring_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        empty     = (count == '0);
        full      = (count == DEPTH_CNT);
        head_data = data_mem[head];
        // Modular subtraction gives the correct age even after t has wrapped.
        head_age  = t - ts_mem[head];

        // Pop looks only at entries present before this edge, so an entry
        // pushed in the same cycle can never be popped in that cycle.
        pop_acc   = en & pop & ~empty;

        // Expiry is the lower-priority way to remove the head. A pop of the
        // same head always wins, and at most one entry leaves per edge.
        exp_acc   = EXPIRY_ON & en & ~pop_acc & ~empty & (head_age >= MAX_AGE_TS);

        // A full queue can still take a push if the head leaves this edge.
        head_adv  = pop_acc | exp_acc;
        push_acc  = en & push & (~full | head_adv);

        head_next = head_adv ? ring_inc(head) : head;
        tail_next = push_acc ? ring_inc(tail) : tail;

        count_next = count;
        case ({push_acc, head_adv})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers and registered responses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            t          <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            push_valid <= 1'b0;
            pop_valid  <= 1'b0;
            out        <= '0;
            waited     <= '0;
            expired    <= 1'b0;
        end else if (en) begin
            t          <= t + TS_W'(1);
            head       <= head_next;
            tail       <= tail_next;
            count      <= count_next;
            push_valid <= push_acc;
            pop_valid  <= pop_acc;
            out        <= pop_acc ? head_data : '0;
            waited     <= pop_acc ? head_age : '0;
            expired    <= exp_acc;
        end
    end

    // -------------------------------------------------------------------------
    // Storage write: the entry is stamped with t as sampled at the push edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            data_mem[tail] <= data;
            ts_mem[tail]   <= t;
        end
    end

endmodule

// File: tb/tb_time_tracking_window_queue.sv
// -----------------------------------------------------------------------------
// Testbench for time_tracking_window_queue.
//
// Two instances share one stimulus bus:
//   dut_a: DATA_W=64, DEPTH=5, TS_W=32, MAX_AGE=0 (defaults, no expiry)
//   dut_b: DATA_W=16, DEPTH=3, TS_W=4,  MAX_AGE=8 (expiry, timestamp wrap)
// A reference model for each instance keeps its entries as an ordered list.
// Each entry stores an absolute push time, and ages are reduced modulo
// 2^TS_W only when compared or reported.
// -----------------------------------------------------------------------------
module tb_time_tracking_window_queue;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        push;
    logic        pop;
    logic [63:0] data_in;

    logic        a_push_valid, a_pop_valid, a_expired;
    logic [63:0] a_out;
    logic [31:0] a_waited;
    logic [2:0]  a_count;

    logic        b_push_valid, b_pop_valid, b_expired;
    logic [15:0] b_out;
    logic [3:0]  b_waited;
    logic [1:0]  b_count;

    time_tracking_window_queue #(
        .DATA_W(64), .DEPTH(5), .TS_W(32), .MAX_AGE(0)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop),
        .data(data_in),
        .push_valid(a_push_valid), .pop_valid(a_pop_valid),
        .out(a_out), .waited(a_waited), .expired(a_expired),
        .count(a_count)
    );

    time_tracking_window_queue #(
        .DATA_W(16), .DEPTH(3), .TS_W(4), .MAX_AGE(8)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop),
        .data(data_in[15:0]),
        .push_valid(b_push_valid), .pop_valid(b_pop_valid),
        .out(b_out), .waited(b_waited), .expired(b_expired),
        .count(b_count)
    );

    // ---------------- reference model ----------------
    int          p_depth [2];
    logic [63:0] p_tmask [2];
    logic [63:0] p_dmask [2];
    logic [63:0] p_age   [2];

    logic [63:0] m_data [2][8];
    logic [63:0] m_ts   [2][8];
    int          m_cnt  [2];
    logic [63:0] m_t    [2];

    logic        e_pv   [2];
    logic        e_popv [2];
    logic        e_exp  [2];
    logic [63:0] e_out  [2];
    logic [63:0] e_wait [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int k, input logic r, input logic e,
                              input logic pu, input logic po, input logic [63:0] d);
        logic [63:0] age;
        logic        pop_ok;
        logic        exp_ok;
        logic        push_ok;
        if (r) begin
            m_cnt[k]  = 0;
            m_t[k]    = 0;
            e_pv[k]   = 1'b0;
            e_popv[k] = 1'b0;
            e_exp[k]  = 1'b0;
            e_out[k]  = 0;
            e_wait[k] = 0;
            return;
        end
        if (!e) return;
        pop_ok = po && (m_cnt[k] > 0);
        age    = (m_cnt[k] > 0) ? ((m_t[k] - m_ts[k][0]) & p_tmask[k]) : 64'd0;
        exp_ok = (p_age[k] != 0) && !pop_ok && (m_cnt[k] > 0) && (age >= p_age[k]);
        e_popv[k] = pop_ok;
        e_out[k]  = pop_ok ? m_data[k][0] : 64'd0;
        e_wait[k] = pop_ok ? age : 64'd0;
        e_exp[k]  = exp_ok;
        if (pop_ok || exp_ok) begin
            for (int i = 0; i < 7; i++) begin
                m_data[k][i] = m_data[k][i+1];
                m_ts[k][i]   = m_ts[k][i+1];
            end
            m_cnt[k]--;
        end
        push_ok = pu && (m_cnt[k] < p_depth[k]);
        if (push_ok) begin
            m_data[k][m_cnt[k]] = d & p_dmask[k];
            m_ts[k][m_cnt[k]]   = m_t[k];
            m_cnt[k]++;
        end
        e_pv[k] = push_ok;
        m_t[k]  = m_t[k] + 64'd1;
    endtask

    task automatic compare_all();
        check("a_push_valid", 64'(a_push_valid), 64'(e_pv[0]));
        check("a_pop_valid",  64'(a_pop_valid),  64'(e_popv[0]));
        check("a_out",        a_out,             e_out[0]);
        check("a_waited",     64'(a_waited),     e_wait[0]);
        check("a_expired",    64'(a_expired),    64'(e_exp[0]));
        check("a_count",      64'(a_count),      64'(m_cnt[0]));
        check("b_push_valid", 64'(b_push_valid), 64'(e_pv[1]));
        check("b_pop_valid",  64'(b_pop_valid),  64'(e_popv[1]));
        check("b_out",        64'(b_out),        e_out[1]);
        check("b_waited",     64'(b_waited),     e_wait[1]);
        check("b_expired",    64'(b_expired),    64'(e_exp[1]));
        check("b_count",      64'(b_count),      64'(m_cnt[1]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic r, input logic e, input logic pu,
                         input logic po, input logic [63:0] d);
        rst     = r;
        en      = e;
        push    = pu;
        pop     = po;
        data_in = d;
        @(posedge clk);
        model_step(0, r, e, pu, po, d);
        model_step(1, r, e, pu, po, d);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic do_reset();                  cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'd0); endtask
    task automatic idle();                      cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0); endtask
    task automatic do_push(input logic [63:0] d); cycle(1'b0, 1'b1, 1'b1, 1'b0, d);   endtask
    task automatic do_pop();                    cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'd0); endtask
    task automatic do_both(input logic [63:0] d); cycle(1'b0, 1'b1, 1'b1, 1'b1, d);   endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] drain_exp [5];
        p_depth[0] = 5;  p_tmask[0] = 64'hFFFF_FFFF; p_dmask[0] = '1;          p_age[0] = 64'd0;
        p_depth[1] = 3;  p_tmask[1] = 64'hF;         p_dmask[1] = 64'hFFFF;    p_age[1] = 64'd8;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_t[k] = 0;
            e_pv[k] = 0; e_popv[k] = 0; e_exp[k] = 0; e_out[k] = 0; e_wait[k] = 0;
        end
        rst = 1'b1; en = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;

        // Reset state
        do_reset();
        do_reset();
        check("rst_count",     64'(a_count),     64'd0);
        check("rst_pop_valid", 64'(a_pop_valid), 64'd0);

        // Basic waited accounting: pushes at t=0,2,4
        do_push(64'd1);
        idle();
        do_push(64'd2);
        idle();
        do_push(64'd3);
        do_pop();                          // t=5
        check("basic_out1",    a_out,             64'd1);
        check("basic_wait1",   64'(a_waited),     64'd5);
        do_both(64'd4);                    // t=6, 4 stamped 6
        check("basic_out2",    a_out,             64'd2);
        do_both(64'd5);                    // t=7
        check("basic_out3",    a_out,             64'd3);
        do_pop();                          // t=8
        check("basic_out4",    a_out,             64'd4);
        check("basic_wait4",   64'(a_waited),     64'd2);
        do_pop();
        do_both(64'd9);                    // on empty
        check("empty_both_pv", 64'(a_push_valid), 64'd1);
        check("empty_both_pp", 64'(a_pop_valid),  64'd0);
        check("empty_both_out", a_out,            64'd0);
        do_pop();

        // Full boundary
        for (int i = 0; i < 5; i++) do_push(64'(10 + i));
        do_push(64'd15);
        check("full_push_rej", 64'(a_push_valid), 64'd0);
        check("full_count",    64'(a_count),      64'd5);
        do_both(64'd16);
        check("full_both_out", a_out,             64'd10);
        check("full_both_pv",  64'(a_push_valid), 64'd1);
        check("full_both_cnt", 64'(a_count),      64'd5);
        drain_exp = '{64'd11, 64'd12, 64'd13, 64'd14, 64'd16};
        for (int i = 0; i < 5; i++) begin
            do_pop();
            check("full_drain", a_out, drain_exp[i]);
        end

        // Expiry on dut_b (MAX_AGE=8)
        do_push(64'd7);
        for (int i = 0; i < 7; i++) begin
            idle();
            check("exp_early", 64'(b_expired), 64'd0);
        end
        idle();
        check("exp_fire",      64'(b_expired),   64'd1);
        check("exp_count",     64'(b_count),     64'd0);
        do_pop();
        check("exp_pop_rej",   64'(b_pop_valid), 64'd0);
        do_push(64'd7);
        for (int i = 0; i < 7; i++) idle();
        do_pop();
        check("exp_pop_wins",  64'(b_pop_valid), 64'd1);
        check("exp_pop_wait",  64'(b_waited),    64'd8);
        check("exp_pop_noexp", 64'(b_expired),   64'd0);

        // Enable freeze
        do_push(64'd42);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom});
            check("freeze_hold_pv", 64'(a_push_valid), 64'd1);
        end
        do_pop();
        check("freeze_wait_a", 64'(a_waited), 64'd1);
        check("freeze_wait_b", 64'(b_waited), 64'd1);
        check("freeze_out",    a_out,         64'd42);

        // Reset mid-operation
        do_push(64'd11);
        do_push(64'd12);
        do_push(64'd13);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 64'd5);
        check("mid_rst_count", 64'(a_count),      64'd0);
        check("mid_rst_pv",    64'(a_push_valid), 64'd0);
        check("mid_rst_out",   a_out,             64'd0);
        do_pop();
        check("mid_rst_pop",   64'(a_pop_valid),  64'd0);
        do_push(64'd77);
        do_pop();
        check("mid_rst_wait",  64'(a_waited),     64'd1);
        check("mid_rst_out2",  a_out,             64'd77);

        // Timestamp wrap on dut_b (TS_W=4): push at t=14, pop at t=3
        do_reset();
        for (int i = 0; i < 14; i++) idle();
        do_push(64'd5);
        for (int i = 0; i < 4; i++) idle();
        do_pop();
        check("wrap_pop",  64'(b_pop_valid), 64'd1);
        check("wrap_wait", 64'(b_waited),    64'd5);

        // Randomized traffic: push-heavy, then pop-heavy
        for (int i = 0; i < 3000; i++) begin
            logic r, e, pu, po;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 9) != 0);
            if (i < 1500) begin
                pu = ($urandom_range(0, 3) != 0);
                po = ($urandom_range(0, 2) == 0);
            end else begin
                pu = ($urandom_range(0, 2) == 0);
                po = ($urandom_range(0, 3) != 0);
            end
            cycle(r, e, pu, po, {$urandom, $urandom});
        end

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
